// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional ALU_ARB_DIVZERO_CHK_EN: flag DIV/REM with b==0 and return all-ones.
module alu_share_arb #(
    parameter int WIDTH = 19,
    parameter int NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*4-1:0]     req_op,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_zero,
    output logic                  rsp_err,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [3:0]            alu_cntrl,
    input  logic [WIDTH-1:0]      alu_out,
    input  logic                  alu_zero,
    output logic                  busy
);

    if (NREQ != 2) begin : g_nreq_chk
        $error("alu_share_arb: NREQ must be 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rr_ptr;
    logic             owner;
    logic             grant;
    logic             accept;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [3:0]       sel_op;

    // rr_ptr requester first, the other one only if rr_ptr is idle
    always_comb begin
        grant = rr_ptr;
        if (!req_valid[rr_ptr]) begin
            grant = ~rr_ptr;
        end
    end

    always_comb begin
        sel_a  = req_a[WIDTH-1:0];
        sel_b  = req_b[WIDTH-1:0];
        sel_op = req_op[3:0];
        if (grant) begin
            sel_a  = req_a[2*WIDTH-1 -: WIDTH];
            sel_b  = req_b[2*WIDTH-1 -: WIDTH];
            sel_op = req_op[7:4];
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req_valid) begin
                    req_ready[grant] = 1'b1;
                    accept           = 1'b1;
                    state_nxt        = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid[owner] = 1'b1;
                if (rsp_ready[owner]) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            owner     <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_cntrl <= 4'b1111;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner     <= grant;
                rr_ptr    <= ~grant;
                alu_a     <= sel_a;
                alu_b     <= sel_b;
                alu_cntrl <= sel_op;
            end
        end
    end

`ifdef ALU_ARB_DIVZERO_CHK_EN
    logic divz;
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divz     <= 1'b0;
            err_q    <= 1'b0;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
        end else begin
            if (accept) begin
                divz  <= ((sel_op == 4'b0011) || (sel_op == 4'b1010))
                         && (sel_b == '0);
                err_q <= 1'b0;
            end
            if (state == EXEC) begin
                if (divz) begin
                    rsp_data <= {WIDTH{1'b1}};
                    rsp_zero <= 1'b0;
                    err_q    <= 1'b1;
                end else begin
                    rsp_data <= alu_out;
                    rsp_zero <= alu_zero;
                end
            end
        end
    end

    assign rsp_err = err_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_zero <= 1'b0;
        end else if (state == EXEC) begin
            rsp_data <= alu_out;
            rsp_zero <= alu_zero;
        end
    end

    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural stand-in ALU.
// Vector table for single ops, hand sequences for arbitration corners.
module tb_alu_share_arb;

    localparam int W = 19;

    logic          clk;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic [7:0]    req_op;
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          rsp_zero;
    logic          rsp_err;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [3:0]    alu_cntrl;
    logic [W-1:0]  alu_out;
    logic          alu_zero;
    logic          busy;

    int checks;
    int failures;

    alu_share_arb #(.WIDTH(W), .NREQ(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cntrl (alu_cntrl),
        .alu_out   (alu_out),
        .alu_zero  (alu_zero),
        .busy      (busy)
    );

    // Stand-in ALU: add, sub, mul, div, rem; anything else yields 0
    always_comb begin
        alu_out = '0;
        case (alu_cntrl)
            4'b0000: alu_out = alu_a + alu_b;
            4'b0001: alu_out = alu_a - alu_b;
            4'b0010: alu_out = W'(alu_a * alu_b);
            4'b0011: alu_out = (alu_b == '0) ? '0 : alu_a / alu_b;
            4'b1010: alu_out = (alu_b == '0) ? '0 : alu_a % alu_b;
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == '0);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         port;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0] op;
        logic [W-1:0] d;
        logic       z;
        logic       e;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int p, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [3:0] op);
        req_a[p*W +: W] = a;
        req_b[p*W +: W] = b;
        req_op[p*4 +: 4] = op;
    endtask

    task automatic do_op(input vec_t v);
        logic [1:0] oh;
        oh = (v.port == 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        set_req(v.port, v.a, v.b, v.op);
        req_valid = oh;
        #1 chk("req_ready", 32'(req_ready), 32'(oh));
        @(negedge clk);
        req_valid = 2'b00;
        #1 chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("alu_a", 32'(alu_a), 32'(v.a));
        chk("alu_b", 32'(alu_b), 32'(v.b));
        chk("alu_cntrl", 32'(alu_cntrl), 32'(v.op));
        @(negedge clk);
        #1 chk("rsp_valid", 32'(rsp_valid), 32'(oh));
        chk("rsp_data", 32'(rsp_data), 32'(v.d));
        chk("rsp_zero", 32'(rsp_zero), 32'(v.z));
        chk("rsp_err", 32'(rsp_err), 32'(v.e));
        rsp_ready = oh;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1 chk("done_busy", 32'(busy), 32'd0);
        chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;

        tbl[0] = '{0, 19'd5, 19'd3, 4'b0000, 19'd8, 1'b0, 1'b0};
        tbl[1] = '{1, 19'd10, 19'd4, 4'b0001, 19'd6, 1'b0, 1'b0};
        tbl[2] = '{0, 19'd100, 19'd7, 4'b0011, 19'd14, 1'b0, 1'b0};
        tbl[3] = '{1, 19'd100, 19'd7, 4'b1010, 19'd2, 1'b0, 1'b0};
        tbl[4] = '{0, 19'd123, 19'd45, 4'b1111, 19'd0, 1'b1, 1'b0};
        tbl[5] = '{1, 19'h7FFFF, 19'd1, 4'b0000, 19'd0, 1'b1, 1'b0};
`ifdef ALU_ARB_DIVZERO_CHK_EN
        tbl[6] = '{1, 19'd9, 19'd0, 4'b0011, 19'h7FFFF, 1'b0, 1'b1};
        tbl[7] = '{0, 19'd9, 19'd0, 4'b1010, 19'h7FFFF, 1'b0, 1'b1};
`else
        tbl[6] = '{1, 19'd9, 19'd0, 4'b0011, 19'd0, 1'b1, 1'b0};
        tbl[7] = '{0, 19'd9, 19'd0, 4'b1010, 19'd0, 1'b1, 1'b0};
`endif
        tbl[8] = '{0, 19'd300, 19'd2, 4'b0010, 19'd600, 1'b0, 1'b0};

        #2 rst_n = 1'b0;
        #1 chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_alu_cntrl", 32'(alu_cntrl), 32'hF);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // contention from reset: req0, then req1, then req0 again
        @(negedge clk);
        set_req(0, 19'd10, 19'd10, 4'b0001);
        set_req(1, 19'd6, 19'd7, 4'b0010);
        req_valid = 2'b11;
        #1 chk("cont_grant0", 32'(req_ready), 32'b01);
        @(negedge clk);
        #1 chk("cont_exec_ready", 32'(req_ready), 32'b00);
        @(negedge clk);
        #1 chk("cont_rsp0_valid", 32'(rsp_valid), 32'b01);
        chk("cont_rsp0_data", 32'(rsp_data), 32'd0);
        chk("cont_rsp0_zero", 32'(rsp_zero), 32'd1);
        rsp_ready = 2'b11;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1 chk("cont_grant1", 32'(req_ready), 32'b10);
        @(negedge clk);
        @(negedge clk);
        #1 chk("cont_rsp1_valid", 32'(rsp_valid), 32'b10);
        chk("cont_rsp1_data", 32'(rsp_data), 32'd42);
        chk("cont_rsp1_zero", 32'(rsp_zero), 32'd0);
        rsp_ready = 2'b10;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1 chk("cont_grant0_again", 32'(req_ready), 32'b01);
        req_valid = 2'b00;

        // backpressure with non-owner ready toggling
        @(negedge clk);
        set_req(0, 19'd1, 19'd2, 4'b0000);
        set_req(1, 19'd4, 19'd4, 4'b0000);
        req_valid = 2'b11;
        #1 chk("bp_grant0", 32'(req_ready), 32'b01);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rsp_ready = (i % 2 == 1) ? 2'b10 : 2'b00;
            #1 chk("bp_rsp_valid", 32'(rsp_valid), 32'b01);
            chk("bp_rsp_data", 32'(rsp_data), 32'd3);
            chk("bp_req_ready", 32'(req_ready), 32'b00);
            @(negedge clk);
        end
        rsp_ready = 2'b10;
        #1 chk("nonowner_pending", 32'(rsp_valid), 32'b01);
        chk("nonowner_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rsp_ready = 2'b01;
        #1 chk("bp_still_valid", 32'(rsp_valid), 32'b01);
        @(negedge clk);
        rsp_ready = 2'b00;
        #1 chk("bp_grant1", 32'(req_ready), 32'b10);
        @(negedge clk);
        req_valid = 2'b00;
        #1 chk("bp_alu_a1", 32'(alu_a), 32'd4);
        @(negedge clk);
        #1 chk("bp_rsp1_valid", 32'(rsp_valid), 32'b10);
        chk("bp_rsp1_data", 32'(rsp_data), 32'd8);
        rsp_ready = 2'b10;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1 chk("bp_idle", 32'(busy), 32'd0);

        for (int i = 0; i < 9; i++) begin
            do_op(tbl[i]);
        end

        // reset while in EXEC discards the operation
        @(negedge clk);
        set_req(0, 19'd5, 19'd3, 4'b0000);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        #1 chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1 chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_alu_cntrl", 32'(alu_cntrl), 32'hF);
        chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
        chk("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
            chk("post_rst_idle", 32'(busy), 32'd0);
        end
        rsp_ready = 2'b00;
        req_valid = 2'b11;
        #1 chk("post_rst_rr0", 32'(req_ready), 32'b01);
        req_valid = 2'b00;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares the single combinational 19-bit ALU between two requesters, e.g. the core execute path (port 0) and a debug/address-generation engine (port 1).
- Per-requester valid/ready request and response channels; round-robin arbitration.
- Registers the ALU operands and opcode, and captures the ALU result into a held response register.
- Sits between the requesters and the ALU instance; the ALU's a/b/alu_cntrl inputs and alu_out/zero outputs connect directly to this block.

Parameters:
- WIDTH, 19, operand/result width; must match the ALU.
- NREQ, 2, number of requesters; fixed at 2 in this revision (elaborate-time error otherwise).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester request accept
- req_a  input  NREQ*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH]
- req_b  input  NREQ*WIDTH  operand B; same slicing as req_a
- req_op  input  NREQ*4  4-bit ALU opcode per requester, ALU encoding
- rsp_valid  output  NREQ  one-hot response valid to the owning requester
- rsp_ready  input  NREQ  per-requester response accept
- rsp_data  output  WIDTH  result, shared bus
- rsp_zero  output  1  ALU zero flag for the result
- rsp_err  output  1  divide-by-zero flag (see Optional Feature)
- alu_a  output  WIDTH  to ALU a
- alu_b  output  WIDTH  to ALU b
- alu_cntrl  output  4  to ALU alu_cntrl
- alu_out  input  WIDTH  from ALU
- alu_zero  input  1  from ALU zero
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset values:
  - State IDLE; rr_ptr=0 (requester 0 has priority); owner=0.
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_err=0.
  - alu_a=0, alu_b=0, alu_cntrl=4'b1111 (ALU default, output 0); busy=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = highest-priority valid requester; rr_ptr has priority, the other requester second.
  - req_ready[grant]=1 combinationally, only while in IDLE; all other req_ready bits 0.
  - On req_valid&req_ready:
    - Register that requester's a/b/op into alu_a/alu_b/alu_cntrl.
    - owner<=grant; rr_ptr<=~grant; go to EXEC.
  - No request: stay in IDLE; rr_ptr unchanged.
- EXEC (exactly 1 cycle; the ALU settles combinationally from the registered inputs):
  - rsp_data<=alu_out and rsp_zero<=alu_zero on the clock edge; go to RESP.
- RESP:
  - rsp_valid[owner]=1; rsp_data, rsp_zero and rsp_err held stable.
  - On rsp_ready[owner]: rsp_valid drops next cycle; go to IDLE.
  - rsp_ready of the non-owner is ignored.
- Latency: accept at edge T, rsp_valid high in cycle T+2. Minimum 3 cycles per operation; no overlap in this revision.
- alu_a/alu_b/alu_cntrl change only on accept; they hold their last values in RESP and IDLE.
- Simultaneous requests: the rr_ptr requester wins. A loser that keeps req_valid high is granted next, so no requester waits more than one operation.
- req_valid may drop before acceptance; no request is latched without handshake.
- Asynchronous reset in any state: all registers return to reset values immediately; an in-flight response is discarded.
- Opcodes 4'b1111 and other undefined ops are passed through unchanged; the ALU returns 0, so rsp_zero=1.

Optional Feature:
- Macro: ALU_ARB_DIVZERO_CHK_EN.
- Defined: if the accepted op is 4'b0011 (DIV) or 4'b1010 (REM) and b==0:
  - In EXEC, rsp_data<={WIDTH{1'b1}}, rsp_zero=0, rsp_err=1; alu_out is ignored.
  - rsp_err is cleared to 0 on the next accept.
- Undefined: rsp_err tied 0; the ALU result is returned unchanged.

Test Plan:
- Reset then idle: rst_n low mid-EXEC -> busy=0, rsp_valid=00, alu_cntrl=4'b1111 immediately; no response after release.
- Single op: req0 a=5 b=3 op=0000, rsp_ready0=1 -> rsp_valid=01 exactly 2 cycles after accept, rsp_data=8, rsp_zero=0.
- Contention: both valid at once from reset -> req0 granted first (SUB 10-10: rsp_data=0, rsp_zero=1), then req1 granted (MUL 6*7=42); a third simultaneous pair grants req0 again.
- Backpressure: owner holds rsp_ready=0 for 4 cycles -> rsp_valid and rsp_data stable throughout, req_ready=00, the other requester is not accepted until the handshake completes.
- Divide by zero: req1 op=0011 a=9 b=0 -> with macro, rsp_data=19'h7FFFF and rsp_err=1; without macro, rsp_err=0 and rsp_data equals alu_out.
- Non-owner ready: owner=0 in RESP, rsp_ready=10 -> no state change; response is still pending.
